alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the combinational 4-bit ALU.
- Operands are `WIDTH` bits wide and are accepted over a valid/ready handshake.
- Carry and borrow are kept in an internal flag register, so ADC/SBB chain across operations without external feedback.
- Adds iterative variable-distance shifts and an iterative unsigned multiply with a double-width result.
- Sits between the instruction decoder (producer) and the register-file write-back stage (consumer).

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_seq_comb.sv | 60 ++++++
 rtl/alu_seq.sv | 135 +++++++++++++
 tb/tb_alu_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions,
// controller state encoding and small opcode classification helpers.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SBB  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_NAND = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_MUL  = 4'hC;
  localparam logic [3:0] OP_CMP  = 4'hD;

  localparam int F_C  = 0;
  localparam int F_B  = 1;
  localparam int F_Z  = 2;
  localparam int F_LT = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == OP_SHL) || (code == OP_SHR);
  endfunction

  // Opcodes above CMP are reserved and leave LT untouched.
  function automatic logic is_reserved(input logic [3:0] code);
    return code > OP_CMP;
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle datapath: add/sub with carry and borrow chaining, logic ops.
// Shifts return a unchanged (the zero-distance case); MUL and reserved give 0.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             c_in,
  input  logic             b_in,
  output logic [WIDTH-1:0] res,
  output logic             c_out,
  output logic             b_out
);

  logic [WIDTH:0] wide;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    res   = '0;
    c_out = 1'b0;
    b_out = 1'b0;
    wide  = '0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        res   = wide[WIDTH-1:0];
        c_out = wide[WIDTH];
      end
      OP_ADC: begin
        wide  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
        res   = wide[WIDTH-1:0];
        c_out = wide[WIDTH];
      end
      // Borrow is the sign of the (WIDTH+1)-bit difference.
      OP_SUB, OP_CMP: begin
        wide  = {1'b0, a} - {1'b0, b};
        res   = wide[WIDTH-1:0];
        b_out = wide[WIDTH];
      end
      OP_SBB: begin
        wide  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, b_in};
        res   = wide[WIDTH-1:0];
        b_out = wide[WIDTH];
      end
      OP_SHL, OP_SHR: res = a;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NOT:  res = ~a;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes, a chained carry/borrow flag
// register, iterative one-bit-per-cycle shifts and a shift-add multiplier.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, next_state;
  logic [3:0]         op_q;
  logic               lt_q;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      count;

  logic               accept, commit, long_op;
  logic [WIDTH-1:0]   comb_res;
  logic               comb_c, comb_b;
  logic [WIDTH-1:0]   shift_next;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [3:0]         cur_op;
  logic               cur_lt;
  logic [WIDTH-1:0]   fin_res, fin_hi;
  logic [3:0]         new_flags;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .a     (a),
    .b     (b),
    .op    (op),
    .c_in  (flags[F_C]),
    .b_in  (flags[F_B]),
    .res   (comb_res),
    .c_out (comb_c),
    .b_out (comb_b)
  );

  assign long_op = (op == OP_MUL) || (is_shift(op) && (b != '0));

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs as they were before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (in_valid)          next_state = long_op ? S_BUSY : S_DONE;
      S_BUSY:  if (count == CW'(1))   next_state = S_DONE;
      S_DONE:  if (out_ready)         next_state = S_IDLE;
      default:                        next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    accept    = (state == S_IDLE) && in_valid;
    commit    = (state != S_DONE) && (next_state == S_DONE);
  end

  // One iteration step for each long operation.
  assign shift_next = (op_q == OP_SHL) ? (shreg << 1) : (shreg >> 1);
  assign mul_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next  = {mul_sum, prod[WIDTH-1:1]};

  // Final result and flags, valid in the cycle that enters DONE.
  always_comb begin
    cur_op  = (state == S_IDLE) ? op : op_q;
    cur_lt  = (state == S_IDLE) ? (a < b) : lt_q;
    fin_res = comb_res;
    fin_hi  = '0;
    if (state == S_BUSY) begin
      if (op_q == OP_MUL) {fin_hi, fin_res} = prod_next;
      else                fin_res = shift_next;
    end
    new_flags        = flags;
    new_flags[F_Z]   = (fin_res == '0) && (fin_hi == '0);
    if (!is_reserved(cur_op))                 new_flags[F_LT] = cur_lt;
    if (cur_op inside {OP_ADD, OP_ADC})       new_flags[F_C]  = comb_c;
    if (cur_op inside {OP_SUB, OP_SBB, OP_CMP}) new_flags[F_B] = comb_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      lt_q      <= 1'b0;
      shreg     <= '0;
      mcand     <= '0;
      prod      <= '0;
      count     <= '0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
    end else begin
      if (accept) begin
        op_q  <= op;
        lt_q  <= (a < b);
        shreg <= a;
        mcand <= a;
        prod  <= {{WIDTH{1'b0}}, b};
        // Shift distance saturates at WIDTH; MUL always iterates WIDTH times.
        count <= ((op == OP_MUL) || (b >= WIDTH'(WIDTH))) ? CW'(WIDTH) : CW'(b);
      end else if (state == S_BUSY) begin
        count <= count - CW'(1);
        shreg <= shift_next;
        prod  <= prod_next;
      end
      if (commit) begin
        result    <= fin_res;
        result_hi <= fin_hi;
        flags     <= new_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=4): directed plan steps plus random
// operations compared against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready;
  logic [W-1:0] a_i, b_i;
  logic [3:0]   op_i;
  logic         in_ready, out_valid;
  logic [W-1:0] result, result_hi;
  logic [3:0]   flags;

  int checks   = 0;
  int failures = 0;

  // Reference model state and expectations for the current operation.
  bit         mc, mb, mz, mlt;
  int         exp_r, exp_h, exp_lat;
  logic [3:0] exp_f;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .op        (op_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] o, input int av, input int bv);
    int s;
    int nb;
    exp_r   = 0;
    exp_h   = 0;
    exp_lat = 1;
    case (o)
      OP_ADD:  begin s = av + bv; exp_r = s & MASK; mc = (s > MASK); end
      OP_ADC:  begin s = av + bv + int'(mc); exp_r = s & MASK; mc = (s > MASK); end
      OP_SUB, OP_CMP: begin exp_r = (av - bv) & MASK; mb = (av < bv); end
      OP_SBB:  begin nb = int'(mb); exp_r = (av - bv - nb) & MASK; mb = (av < bv + nb); end
      OP_SHL:  begin exp_r = (bv >= W) ? 0 : ((av << bv) & MASK); exp_lat = 1 + ((bv < W) ? bv : W); end
      OP_SHR:  begin exp_r = (bv >= W) ? 0 : (av >> bv); exp_lat = 1 + ((bv < W) ? bv : W); end
      OP_AND:  exp_r = av & bv;
      OP_OR:   exp_r = av | bv;
      OP_NOT:  exp_r = (~av) & MASK;
      OP_XOR:  exp_r = av ^ bv;
      OP_NAND: exp_r = (~(av & bv)) & MASK;
      OP_NOR:  exp_r = (~(av | bv)) & MASK;
      OP_MUL:  begin s = av * bv; exp_r = s & MASK; exp_h = s >> W; exp_lat = 1 + W; end
      default: exp_r = 0;
    endcase
    mz = (exp_r == 0) && (exp_h == 0);
    if (o <= OP_CMP) mlt = (av < bv);
    exp_f = {mlt, mz, mb, mc};
  endtask

  task automatic issue(input logic [3:0] o, input int av, input int bv);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_accept", in_ready, 1);
    op_i     = o;
    a_i      = av[W-1:0];
    b_i      = bv[W-1:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Operand changes after accept must have no effect.
    in_valid = 1'b0;
    op_i     = 4'($urandom);
    a_i      = W'($urandom);
    b_i      = W'($urandom);
  endtask

  task automatic finish_op(input string tag, input int hold);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    check($sformatf("%s.latency", tag), lat, exp_lat);
    check($sformatf("%s.result", tag), result, exp_r);
    check($sformatf("%s.result_hi", tag), result_hi, exp_h);
    check($sformatf("%s.flags", tag), flags, exp_f);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op_i     = OP_MUL;
      a_i      = W'($urandom);
      b_i      = W'($urandom);
      @(negedge clk);
      check($sformatf("%s.hold%0d.out_valid", tag, i), out_valid, 1);
      check($sformatf("%s.hold%0d.in_ready", tag, i), in_ready, 0);
      check($sformatf("%s.hold%0d.result", tag, i), result, exp_r);
      check($sformatf("%s.hold%0d.flags", tag, i), flags, exp_f);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check($sformatf("%s.handoff.out_valid", tag), out_valid, 0);
    check($sformatf("%s.handoff.in_ready", tag), in_ready, 1);
    if (hold > 0) begin
      @(negedge clk);
      check($sformatf("%s.no_spurious_op", tag), out_valid, 0);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input int av, input int bv,
                        input int hold);
    model(o, av, bv);
    issue(o, av, bv);
    finish_op(tag, hold);
  endtask

  task automatic check_reset_state(input string tag);
    check($sformatf("%s.in_ready", tag), in_ready, 1);
    check($sformatf("%s.out_valid", tag), out_valid, 0);
    check($sformatf("%s.result", tag), result, 0);
    check($sformatf("%s.result_hi", tag), result_hi, 0);
    check($sformatf("%s.flags", tag), flags, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_i       = '0;
    b_i       = '0;
    op_i      = '0;
    {mc, mb, mz, mlt} = 4'b0000;

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Carry chain, borrow chain, compare.
    run_op("add_9_8", OP_ADD, 9, 8, 0);
    run_op("adc_2_3", OP_ADC, 2, 3, 0);
    run_op("sub_3_5", OP_SUB, 3, 5, 0);
    run_op("sbb_5_2", OP_SBB, 5, 2, 0);
    run_op("cmp_4_4", OP_CMP, 4, 4, 0);

    // Iterative operations and zero-distance shift.
    run_op("mul_f_f", OP_MUL, 15, 15, 0);
    run_op("shl_3_2", OP_SHL, 3, 2, 0);
    run_op("shr_8_7", OP_SHR, 8, 7, 0);
    run_op("shl_5_0", OP_SHL, 5, 0, 0);
    run_op("rsvd_e", 4'hE, 6, 9, 0);

    // Backpressure in DONE with a competing request.
    run_op("bp_add", OP_ADD, 7, 6, 3);

    // Asynchronous reset in the second BUSY cycle of a multiply.
    run_op("pre_reset_sub", OP_SUB, 3, 5, 0);
    issue(OP_MUL, 15, 15);
    @(posedge clk);
    #1;
    check("mid_mul.out_valid", out_valid, 0);
    check("mid_mul.in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_mul_reset");
    {mc, mb, mz, mlt} = 4'b0000;
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op("post_reset_add", OP_ADD, 1, 1, 0);

    for (int i = 0; i < 60; i++) begin
      run_op($sformatf("rand%0d", i), 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
